fifo_wptr_full_ctrl: RTL and testbench

//  Write-side controller of the asynchronous FIFO, directly upstream of the dual-port FIFO memory.

---
 rtl/fifo_wptr_full_ctrl.sv | 93 +++++++++
 tb/tb_fifo_wptr_full_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side controller of the asynchronous FIFO: binary/Gray write pointer, read-pointer
// synchroniser, registered full / almost-full / fill level and a sticky overflow flag.
module fifo_wptr_full_ctrl #(
  parameter int ADDR_SIZE   = 4,
  parameter int AFULL_LEVEL = 14
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rptr,
  input  logic                 woverflow_clr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic                 wclk_en,
  output logic                 wfull,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam logic [ADDR_SIZE:0] AFULL_CMP = (ADDR_SIZE + 1)'(AFULL_LEVEL);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] wq1_rptr;
  logic [ADDR_SIZE:0] wq2_rptr;
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] level_next;
  logic [ADDR_SIZE:0] full_gray;

  assign wclk_en = winc & ~wfull;
  assign waddr   = wbin[ADDR_SIZE-1:0];

  assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wclk_en};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);

  // Full means the write pointer is exactly one lap (two top Gray bits inverted) ahead of the reader.
  assign full_gray  = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign level_next = wbin_next - rbin_s;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr <= '0;
      wq2_rptr <= '0;
    end else begin
      wq1_rptr <= rptr;
      wq2_rptr <= wq1_rptr;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin <= '0;
      wptr <= '0;
    end else begin
      wbin <= wbin_next;
      wptr <= wgray_next;
    end
  end

  // Flags use the synchronised read pointer, so they may lag reads but never writes.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wfull        <= (wgray_next == full_gray);
      walmost_full <= (level_next >= AFULL_CMP);
      wlevel       <= level_next;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (woverflow_clr) begin
      woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Self-checking bench for fifo_wptr_full_ctrl: scoreboarded write addresses plus
// scenario tasks for reset, fill, overflow, drain latency, wrap and async reset.
module tb_fifo_wptr_full_ctrl;
  localparam int A = 4;

  logic         wclk = 1'b0;
  logic         wrst_n;
  logic         winc;
  logic [A:0]   rptr;
  logic         woverflow_clr;
  logic [A-1:0] waddr;
  logic         wclk_en;
  logic         wfull;
  logic [A:0]   wptr;
  logic         walmost_full;
  logic [A:0]   wlevel;
  logic         woverflow;

  int           errors = 0;
  int           checks = 0;
  logic [A-1:0] exp_q[$];
  logic [A-1:0] exp_addr;
  logic [A:0]   m_wbin;

  fifo_wptr_full_ctrl #(.ADDR_SIZE(A), .AFULL_LEVEL(14)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .woverflow_clr(woverflow_clr),
    .waddr(waddr), .wclk_en(wclk_en), .wfull(wfull), .wptr(wptr),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [A:0] gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic pop_addr(input string name);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, waddr=%0d", name, waddr);
    end else begin
      exp_addr = exp_q.pop_front();
      if (waddr !== exp_addr) begin
        errors++;
        $display("FAIL %s: waddr=%0d expected=%0d", name, waddr, exp_addr);
      end
    end
  endtask

  task automatic clean_reset;
    wrst_n = 1'b0; winc = 1'b0; woverflow_clr = 1'b0; rptr = '0;
    #2;
    wrst_n = 1'b1;
    tick; tick; tick;
    m_wbin = '0;
    exp_q.delete();
  endtask

  task automatic test_reset;
    wrst_n = 1'b0; winc = 1'b1; rptr = '0; woverflow_clr = 1'b0;
    #2;
    checks++; if (wptr !== '0) begin errors++; $display("FAIL reset_wptr: got=%b expected=0", wptr); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got=%b expected=0", wfull); end
    checks++; if (wlevel !== '0) begin errors++; $display("FAIL reset_wlevel: got=%0d expected=0", wlevel); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL reset_woverflow: got=%b expected=0", woverflow); end
    checks++; if (waddr !== '0) begin errors++; $display("FAIL reset_waddr: got=%0d expected=0", waddr); end
    checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got=%b expected=0", walmost_full); end
    checks++; if (wclk_en !== 1'b1) begin errors++; $display("FAIL reset_wclk_en: got=%b expected=1", wclk_en); end
    tick; tick;
    checks++; if (wptr !== '0) begin errors++; $display("FAIL reset_hold_wptr: got=%b expected=0", wptr); end
    winc = 1'b0;
    wrst_n = 1'b1;
    tick; tick; tick;
    m_wbin = '0;
    exp_q.delete();
  endtask

  task automatic test_fill;
    rptr = '0;
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1;
      exp_q.push_back(m_wbin[A-1:0]);
      #1;
      checks++; if (wclk_en !== 1'b1) begin errors++; $display("FAIL fill_wclk_en[%0d]: got=%b expected=1", i, wclk_en); end
      pop_addr("fill_waddr");
      tick;
      m_wbin = m_wbin + 1'b1;
      checks++; if (wlevel !== m_wbin) begin errors++; $display("FAIL fill_wlevel[%0d]: got=%0d expected=%0d", i, wlevel, m_wbin); end
      checks++; if (walmost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull[%0d]: got=%b expected=%b", i, walmost_full, (i + 1 >= 14)); end
      checks++; if (wfull !== (i + 1 == 16)) begin errors++; $display("FAIL fill_wfull[%0d]: got=%b expected=%b", i, wfull, (i + 1 == 16)); end
      checks++; if (wptr !== gray(m_wbin)) begin errors++; $display("FAIL fill_wptr[%0d]: got=%b expected=%b", i, wptr, gray(m_wbin)); end
    end
    winc = 1'b0;
    #1;
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL fill_final_wptr: got=%b expected=11000", wptr); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL fill_final_waddr: got=%0d expected=0", waddr); end
    checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL fill_final_wlevel: got=%0d expected=16", wlevel); end
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL fill_no_overflow: got=%b expected=0", woverflow); end
    tick;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 2; i++) begin
      winc = 1'b1;
      #1;
      checks++; if (wclk_en !== 1'b0) begin errors++; $display("FAIL ovf_wclk_en[%0d]: got=%b expected=0", i, wclk_en); end
      tick;
      checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL ovf_wptr[%0d]: got=%b expected=11000", i, wptr); end
      checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d]: got=%b expected=1", i, woverflow); end
      checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL ovf_wfull[%0d]: got=%b expected=1", i, wfull); end
    end
    woverflow_clr = 1'b1; winc = 1'b1;
    tick;
    checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got=%b expected=1", woverflow); end
    woverflow_clr = 1'b1; winc = 1'b0;
    tick;
    checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got=%b expected=0", woverflow); end
    woverflow_clr = 1'b0;
  endtask

  task automatic test_drain;
    rptr = 5'b00001;
    for (int e = 1; e <= 2; e++) begin
      tick;
      checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL drain_early_wfull[%0d]: got=%b expected=1", e, wfull); end
      checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL drain_early_wlevel[%0d]: got=%0d expected=16", e, wlevel); end
    end
    tick;
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL drain_wfull: got=%b expected=0", wfull); end
    checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL drain_wlevel: got=%0d expected=15", wlevel); end
    checks++; if (walmost_full !== 1'b1) begin errors++; $display("FAIL drain_afull: got=%b expected=1", walmost_full); end
  endtask

  task automatic test_wrap;
    logic [A:0] w_1, w_2, r_now, r_1, r_2, exp_lvl;
    clean_reset;
    w_1 = '0; w_2 = '0; r_1 = '0; r_2 = '0;
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1;
      r_now = w_2;
      rptr = gray(r_now);
      exp_q.push_back(m_wbin[A-1:0]);
      #1;
      pop_addr("wrap_waddr");
      tick;
      m_wbin = m_wbin + 1'b1;
      exp_lvl = m_wbin - r_2;
      checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_wfull[%0d]: got=%b expected=0", i, wfull); end
      checks++; if (wptr !== gray(m_wbin)) begin errors++; $display("FAIL wrap_wptr[%0d]: got=%b expected=%b", i, wptr, gray(m_wbin)); end
      checks++; if (wlevel !== exp_lvl) begin errors++; $display("FAIL wrap_wlevel[%0d]: got=%0d expected=%0d", i, wlevel, exp_lvl); end
      w_2 = w_1; w_1 = m_wbin;
      r_2 = r_1; r_1 = r_now;
    end
    winc = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    clean_reset;
    for (int i = 0; i < 9; i++) begin
      winc = 1'b1;
      exp_q.push_back(m_wbin[A-1:0]);
      #1;
      pop_addr("arst_fill_waddr");
      tick;
      m_wbin = m_wbin + 1'b1;
    end
    winc = 1'b0;
    rptr = gray(5'd2);
    tick; tick; tick;
    checks++; if (wlevel !== 5'd7) begin errors++; $display("FAIL arst_pre_wlevel: got=%0d expected=7", wlevel); end
    @(negedge wclk);
    wrst_n = 1'b0;
    rptr = '0;
    #1;
    checks++; if (wptr !== '0) begin errors++; $display("FAIL arst_wptr: got=%b expected=0", wptr); end
    checks++; if (waddr !== '0) begin errors++; $display("FAIL arst_waddr: got=%0d expected=0", waddr); end
    checks++; if (wlevel !== '0) begin errors++; $display("FAIL arst_wlevel: got=%0d expected=0", wlevel); end
    checks++; if (wfull !== 1'b0 || walmost_full !== 1'b0 || woverflow !== 1'b0) begin
      errors++; $display("FAIL arst_flags: got full=%b afull=%b ovf=%b expected all 0", wfull, walmost_full, woverflow);
    end
    tick;
    wrst_n = 1'b1;
    m_wbin = '0;
    winc = 1'b1;
    tick;
    winc = 1'b0;
    checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL arst_post_wlevel: got=%0d expected=1", wlevel); end
    checks++; if (wptr !== gray(5'd1)) begin errors++; $display("FAIL arst_post_wptr: got=%b expected=%b", wptr, gray(5'd1)); end
    tick;
    checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL arst_stale_sync: got=%0d expected=1", wlevel); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_drain;
    test_wrap;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
